// File: rtl/dm_ctrl_pkg.sv
// Shared constants for the data memory controller: access-type encodings,
// FSM state encoding and the alignment/legality rule.
package dm_ctrl_pkg;

    localparam logic [2:0] MT_W  = 3'd0;
    localparam logic [2:0] MT_H  = 3'd1;
    localparam logic [2:0] MT_HU = 3'd2;
    localparam logic [2:0] MT_B  = 3'd3;
    localparam logic [2:0] MT_BU = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // 1 when the access cannot be performed: misaligned for its size,
    // reserved encoding, or an unsigned type used for a store.
    function automatic logic mt_bad(input logic [2:0] mt, input logic [1:0] off,
                                    input logic we);
        logic bad;
        case (mt)
            MT_W:    bad = (off != 2'b00);
            MT_H:    bad = off[0];
            MT_HU:   bad = off[0] | we;
            MT_B:    bad = 1'b0;
            MT_BU:   bad = we;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dm_lane.sv
// Byte-lane logic: store merge into the old word, load extract/extend,
// and the error flag for the access.
module dm_lane
    import dm_ctrl_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  mtype,
    input  logic        we,
    output logic [31:0] new_word,
    output logic [31:0] rdata,
    output logic        err
);

    logic [15:0] half_v;
    logic [7:0]  byte_v;

    // Select the addressed lane, then merge (store) or extend (load).
    always_comb begin
        half_v   = offset[1] ? old_word[31:16] : old_word[15:0];
        byte_v   = old_word[{offset, 3'b000} +: 8];
        err      = mt_bad(mtype, offset, we);
        new_word = old_word;
        rdata    = '0;
        case (mtype)
            MT_W: begin
                new_word = wdata;
                rdata    = old_word;
            end
            MT_H: begin
                if (offset[1]) new_word[31:16] = wdata[15:0];
                else           new_word[15:0]  = wdata[15:0];
                rdata = {{16{half_v[15]}}, half_v};
            end
            MT_HU: rdata = {16'h0000, half_v};
            MT_B: begin
                new_word[{offset, 3'b000} +: 8] = wdata[7:0];
                rdata = {{24{byte_v[7]}}, byte_v};
            end
            MT_BU: rdata = {24'h000000, byte_v};
            default: ;
        endcase
    end

endmodule

// File: rtl/dm_ctrl.sv
// Data memory with req/busy/rvalid handshake and configurable latency.
// Holds the FSM, latency counter, request latches, memory array and store log.
module dm_ctrl
    import dm_ctrl_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [2:0]  mtype,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [31:0] pc,
    output logic        busy,
    output logic        rvalid,
    output logic [31:0] rdata,
    output logic        err
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               err_q, err_d;
    logic               lat_en;

    logic               we_q;
    logic [2:0]         mtype_q;
    logic [31:0]        addr_q;
    logic [31:0]        wdata_q;
    logic [31:0]        pc_q;

    logic [31:0]        mem_q [DEPTH];

    logic [ADDR_W-1:0]  idx;
    logic [31:0]        old_word;
    logic [31:0]        new_word;
    logic [31:0]        lane_rdata;
    logic               lane_err;
    logic               access;
    logic               commit;

    // Upper address bits are dropped so addresses wrap modulo the depth.
    assign idx      = addr_q[ADDR_W+1:2];
    assign old_word = mem_q[idx];
    assign access   = (state_q == ST_WAIT) && (cnt_q == '0);
    assign commit   = access && we_q && !lane_err;

    dm_lane u_lane (
        .old_word (old_word),
        .wdata    (wdata_q),
        .offset   (addr_q[1:0]),
        .mtype    (mtype_q),
        .we       (we_q),
        .new_word (new_word),
        .rdata    (lane_rdata),
        .err      (lane_err)
    );

    // Next-state, counter and response computation.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        lat_en  = 1'b0;
        case (state_q)
            ST_IDLE, ST_RESP: begin
                if (req) begin
                    state_d = ST_WAIT;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    lat_en  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_RESP;
                    rdata_d = (we_q || lane_err) ? 32'h0 : lane_rdata;
                    err_d   = lane_err;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control and response registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Request latches, captured on the accepting edge.
    always_ff @(posedge clk) begin
        if (lat_en) begin
            we_q    <= we;
            mtype_q <= mtype;
            addr_q  <= addr;
            wdata_q <= wdata;
            pc_q    <= pc;
        end
    end

    // Memory array: cleared by reset, read-modify-write on committed stores.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (commit) begin
            mem_q[idx] <= new_word;
        end
    end

`ifndef SYNTHESIS
    // Store log: latched pc, word-aligned byte address, merged word.
    always_ff @(posedge clk) begin
        if (!reset && commit)
            $display("@%h: *%h <= %h", pc_q, {addr_q[31:2], 2'b00}, new_word);
    end
`endif

    assign busy   = (state_q == ST_WAIT);
    assign rvalid = (state_q == ST_RESP);
    assign rdata  = rdata_q;
    assign err    = err_q;

endmodule

// File: tb/tb_dm_ctrl.sv
// Bench for dm_ctrl: a LATENCY=1 instance for data-path cases and a
// LATENCY=3 instance for handshake, held-request and reset-abort cases.
module tb_dm_ctrl;
    import dm_ctrl_pkg::*;

    logic        clk;
    logic        rst1, req1, we1, busy1, rvalid1, err1;
    logic [2:0]  mt1;
    logic [31:0] addr1, wd1, pc1, rdata1;
    logic        rst3, req3, we3, busy3, rvalid3, err3;
    logic [2:0]  mt3;
    logic [31:0] addr3, wd3, pc3, rdata3;

    int tests = 0;
    int fails = 0;

    logic [32:0] q1[$];
    logic [32:0] q3[$];

    dm_ctrl #(.ADDR_W(10), .LATENCY(1)) u1 (
        .clk(clk), .reset(rst1), .req(req1), .we(we1), .mtype(mt1), .addr(addr1),
        .wdata(wd1), .pc(pc1), .busy(busy1), .rvalid(rvalid1), .rdata(rdata1), .err(err1)
    );

    dm_ctrl #(.ADDR_W(10), .LATENCY(3)) u3 (
        .clk(clk), .reset(rst3), .req(req3), .we(we3), .mtype(mt3), .addr(addr3),
        .wdata(wd3), .pc(pc3), .busy(busy3), .rvalid(rvalid3), .rdata(rdata3), .err(err3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard pop/compare on every response pulse.
    always @(negedge clk) begin
        if (rvalid1) begin
            tests++;
            assert (q1.size() != 0) else begin
                fails++;
                $error("FAIL rv1_unexpected: observed rvalid 1 expected 0");
            end
            if (q1.size() != 0) begin
                logic [32:0] e;
                e = q1.pop_front();
                chk("rdata1", rdata1, e[31:0]);
                chk("err1", {31'b0, err1}, {31'b0, e[32]});
            end
        end
        if (rvalid3) begin
            tests++;
            assert (q3.size() != 0) else begin
                fails++;
                $error("FAIL rv3_unexpected: observed rvalid 1 expected 0");
            end
            if (q3.size() != 0) begin
                logic [32:0] e;
                e = q3.pop_front();
                chk("rdata3", rdata3, e[31:0]);
                chk("err3", {31'b0, err3}, {31'b0, e[32]});
            end
        end
    end

    // Called at a negedge with the DUT idle or responding; drives one request,
    // drops req after the accepting edge and measures edges until rvalid.
    task automatic issue(input int sel, input logic w, input logic [2:0] mt,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] p,
                         input logic [31:0] er, input logic ee);
        int n;
        int lat;
        lat = (sel == 1) ? 1 : 3;
        if (sel == 1) begin
            req1 = 1'b1; we1 = w; mt1 = mt; addr1 = a; wd1 = wd; pc1 = p;
            q1.push_back({ee, er});
        end else begin
            req3 = 1'b1; we3 = w; mt3 = mt; addr3 = a; wd3 = wd; pc3 = p;
            q3.push_back({ee, er});
        end
        @(negedge clk);
        if (sel == 1) req1 = 1'b0;
        else          req3 = 1'b0;
        n = 0;
        while (((sel == 1) ? !rvalid1 : !rvalid3) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("latency", 32'(n), 32'(lat));
    endtask

    initial begin
        rst1 = 1'b1; req1 = 1'b0; we1 = 1'b0; mt1 = MT_W; addr1 = '0; wd1 = '0; pc1 = '0;
        rst3 = 1'b1; req3 = 1'b0; we3 = 1'b0; mt3 = MT_W; addr3 = '0; wd3 = '0; pc3 = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy1",   {31'b0, busy1},   32'h0);
        chk("rst_rvalid1", {31'b0, rvalid1}, 32'h0);
        chk("rst_rdata1",  rdata1,           32'h0);
        chk("rst_err1",    {31'b0, err1},    32'h0);
        chk("rst_busy3",   {31'b0, busy3},   32'h0);
        chk("rst_rvalid3", {31'b0, rvalid3}, 32'h0);
        rst1 = 1'b0;
        rst3 = 1'b0;
        @(negedge clk);

        // LATENCY=1 chain, each request issued in the previous RESP cycle
        issue(1, 1'b1, MT_W,  32'h10, 32'h8899AABB, 32'h3000, 32'h0,        1'b0);
        issue(1, 1'b0, MT_W,  32'h10, 32'h0,        32'h3004, 32'h8899AABB, 1'b0);
        issue(1, 1'b1, MT_B,  32'h11, 32'h000000CC, 32'h3008, 32'h0,        1'b0);
        issue(1, 1'b0, MT_W,  32'h10, 32'h0,        32'h300C, 32'h8899CCBB, 1'b0);
        issue(1, 1'b0, MT_B,  32'h11, 32'h0,        32'h3010, 32'hFFFFFFCC, 1'b0);
        issue(1, 1'b0, MT_BU, 32'h11, 32'h0,        32'h3014, 32'h000000CC, 1'b0);
        issue(1, 1'b1, MT_H,  32'h12, 32'h00001234, 32'h3018, 32'h0,        1'b0);
        issue(1, 1'b0, MT_W,  32'h10, 32'h0,        32'h301C, 32'h1234CCBB, 1'b0);
        issue(1, 1'b0, MT_H,  32'h12, 32'h0,        32'h3020, 32'h00001234, 1'b0);
        issue(1, 1'b0, MT_H,  32'h10, 32'h0,        32'h3024, 32'hFFFFCCBB, 1'b0);
        issue(1, 1'b0, MT_HU, 32'h10, 32'h0,        32'h3028, 32'h0000CCBB, 1'b0);
        // error cases
        issue(1, 1'b0, MT_W,  32'h13, 32'h0,        32'h302C, 32'h0,        1'b1);
        issue(1, 1'b1, MT_H,  32'h11, 32'h0000FFFF, 32'h3030, 32'h0,        1'b1);
        issue(1, 1'b0, MT_W,  32'h10, 32'h0,        32'h3034, 32'h1234CCBB, 1'b0);
        issue(1, 1'b0, 3'd6,  32'h10, 32'h0,        32'h3038, 32'h0,        1'b1);
        issue(1, 1'b1, MT_HU, 32'h10, 32'h0000FFFF, 32'h303C, 32'h0,        1'b1);
        issue(1, 1'b0, MT_W,  32'h10, 32'h0,        32'h3040, 32'h1234CCBB, 1'b0);
        // top byte lane store and signed reads of positive values
        issue(1, 1'b1, MT_B,  32'h13, 32'h00000055, 32'h3044, 32'h0,        1'b0);
        issue(1, 1'b0, MT_B,  32'h13, 32'h0,        32'h3048, 32'h00000055, 1'b0);
        issue(1, 1'b0, MT_W,  32'h10, 32'h0,        32'h304C, 32'h5534CCBB, 1'b0);
        // wrap-around: 0x1010 aliases 0x0010
        issue(1, 1'b1, MT_W,  32'h1010, 32'hDEADBEEF, 32'h3050, 32'h0,      1'b0);
        issue(1, 1'b0, MT_W,  32'h0010, 32'h0,        32'h3054, 32'hDEADBEEF, 1'b0);
        @(negedge clk);

        // LATENCY=3: req held through WAIT (ignored) and into RESP (accepted)
        req3 = 1'b1; we3 = 1'b1; mt3 = MT_W; addr3 = 32'h20; wd3 = 32'hA5A5A5A5; pc3 = 32'h4000;
        q3.push_back({1'b0, 32'h0});
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) begin
                chk("hold_busy_k1", {31'b0, busy3}, 32'h1);
                we3 = 1'b0; addr3 = 32'h20; wd3 = 32'h0; pc3 = 32'h4004;
                q3.push_back({1'b0, 32'hA5A5A5A5});
            end
            if (k == 5) begin
                chk("hold_busy_k5", {31'b0, busy3}, 32'h1);
                req3 = 1'b0;
            end
            chk("hold_rvalid", {31'b0, rvalid3}, {31'b0, (k == 4 || k == 8)});
        end

        // reset during WAIT of a store aborts it
        req3 = 1'b1; we3 = 1'b1; mt3 = MT_W; addr3 = 32'h30; wd3 = 32'h12345678; pc3 = 32'h4008;
        @(negedge clk);
        req3 = 1'b0;
        rst3 = 1'b1;
        @(negedge clk);
        rst3 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("abort_rvalid", {31'b0, rvalid3}, 32'h0);
        end
        issue(3, 1'b0, MT_W, 32'h30, 32'h0, 32'h400C, 32'h0, 1'b0);
        issue(3, 1'b0, MT_W, 32'h20, 32'h0, 32'h4010, 32'h0, 1'b0);
        @(negedge clk);
        @(negedge clk);

        chk("q1_drained", 32'(q1.size()), 32'h0);
        chk("q3_drained", 32'(q3.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
